// File: rtl/carrega_operandos.sv
// Assembles two 16-bit operands from a stream of 8-bit bytes and hands the pair
// to the downstream logic stage with a valid/accept handshake.
module carrega_operandos #(
    parameter bit MSB_PRIMEIRO = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_dado,
    input  logic        i_dado_valido,
    output logic        o_pronto,
    input  logic        i_limpa,
    output logic [15:0] o_a,
    output logic [15:0] o_b,
    output logic        o_oper_valido,
    input  logic        i_oper_aceito,
    output logic [7:0]  o_contagem
);

    typedef enum logic [2:0] {
        CARGA_A0,
        CARGA_A1,
        CARGA_B0,
        CARGA_B1,
        ENTREGA
    } t_estado;

    t_estado     r_estado;
    t_estado     w_prox_estado;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [7:0]  r_contagem;

    logic        w_pronto;
    logic        w_transfere;
    logic        w_aceita;
    logic        w_sel_b;
    logic        w_alto;

    // PRONTO comes straight from the state register, never from DADO_VALIDO.
    assign w_pronto    = (r_estado != ENTREGA);
    assign w_transfere = i_dado_valido & w_pronto & ~i_limpa;
    assign w_aceita    = (r_estado == ENTREGA) & i_oper_aceito & ~i_limpa;

    // Second byte of each operand goes to the high lane unless the order is swapped.
    assign w_sel_b = (r_estado == CARGA_B0) || (r_estado == CARGA_B1);
    assign w_alto  = ((r_estado == CARGA_A1) || (r_estado == CARGA_B1)) ^ MSB_PRIMEIRO;

    always_comb begin
        w_prox_estado = r_estado;
        if (i_limpa) begin
            w_prox_estado = CARGA_A0;
        end else begin
            case (r_estado)
                CARGA_A0: if (i_dado_valido) w_prox_estado = CARGA_A1;
                CARGA_A1: if (i_dado_valido) w_prox_estado = CARGA_B0;
                CARGA_B0: if (i_dado_valido) w_prox_estado = CARGA_B1;
                CARGA_B1: if (i_dado_valido) w_prox_estado = ENTREGA;
                ENTREGA:  if (i_oper_aceito) w_prox_estado = CARGA_A0;
                default:  w_prox_estado = CARGA_A0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_estado   <= CARGA_A0;
            r_contagem <= 8'd0;
        end else begin
            r_estado <= w_prox_estado;
            if (w_aceita) begin
                r_contagem <= r_contagem + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= 16'd0;
            r_b <= 16'd0;
        end else if (i_limpa) begin
            r_a <= 16'd0;
            r_b <= 16'd0;
        end else if (w_transfere) begin
            case ({w_sel_b, w_alto})
                2'b00:   r_a[7:0]  <= i_dado;
                2'b01:   r_a[15:8] <= i_dado;
                2'b10:   r_b[7:0]  <= i_dado;
                default: r_b[15:8] <= i_dado;
            endcase
        end
    end

    assign o_pronto      = w_pronto;
    assign o_oper_valido = (r_estado == ENTREGA);
    assign o_a           = r_a;
    assign o_b           = r_b;
    assign o_contagem    = r_contagem;

endmodule

// File: doc/carrega_operandos.md
CARREGA_OPERANDOS -- requirements
Module: carrega_operandos

Interface
REQ-001 The block SHALL have one parameter: MSB_PRIMEIRO, default 0, meaning byte order within each operand (0 = low byte first, 1 = high byte first).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 DADO  input  8  byte from the 8-bit upstream bus.
REQ-006 DADO_VALIDO  input  1  DADO holds a valid byte.
REQ-007 PRONTO  output  1  block can accept a byte this cycle.
REQ-008 LIMPA  input  1  synchronous abort; discards any partial load.
REQ-009 A  output  16  operand A to the 16-bit bitwise logic stage.
REQ-010 B  output  16  operand B to the 16-bit bitwise logic stage.
REQ-011 OPER_VALIDO  output  1  A and B form a complete, stable pair.
REQ-012 OPER_ACEITO  input  1  downstream has consumed the pair.
REQ-013 CONTAGEM  output  8  number of pairs delivered, modulo 256.

Function
REQ-014 The block SHALL transfer a byte on a rising edge only when DADO_VALIDO=1 and PRONTO=1 and LIMPA=0.
REQ-015 The FSM SHALL have states CARGA_A0, CARGA_A1, CARGA_B0, CARGA_B1, ENTREGA, advancing one state per transferred byte in that order.
REQ-016 With MSB_PRIMEIRO=0, bytes SHALL be written to A[7:0], A[15:8], B[7:0], B[15:8] in that order; with MSB_PRIMEIRO=1, to A[15:8], A[7:0], B[15:8], B[7:0].
REQ-017 Bits of A and B not written by the current transfer SHALL hold their value.
REQ-018 PRONTO SHALL be 1 in all four CARGA states and 0 in ENTREGA; PRONTO SHALL NOT depend combinationally on DADO_VALIDO.
REQ-019 The edge that transfers the 4th byte SHALL move the FSM to ENTREGA, and OPER_VALIDO SHALL be 1 from that edge onward (zero added cycles of latency).
REQ-020 In ENTREGA, A, B and OPER_VALIDO SHALL stay constant until an edge with OPER_ACEITO=1.
REQ-021 An edge in ENTREGA with OPER_ACEITO=1 SHALL return the FSM to CARGA_A0, clear OPER_VALIDO, and increment CONTAGEM by 1; A and B keep their values.
REQ-022 CONTAGEM SHALL wrap from 255 to 0 without any flag.
REQ-023 OPER_ACEITO SHALL be ignored in the CARGA states.
REQ-024 DADO_VALIDO SHALL be ignored in ENTREGA; no byte is lost because PRONTO=0 there.
REQ-025 An edge with LIMPA=1 in any state SHALL set the FSM to CARGA_A0, clear A, B and OPER_VALIDO to 0, discard any byte presented that cycle, and leave CONTAGEM unchanged.
REQ-026 If LIMPA=1 and OPER_ACEITO=1 on the same edge in ENTREGA, LIMPA SHALL take precedence, and CONTAGEM SHALL NOT increment.
REQ-027 The next pair's first byte SHALL be transferable on the edge after the OPER_ACEITO edge; peak throughput is 1 pair per 5 cycles.

Reset
REQ-028 While RST_N=0, the block SHALL immediately hold the FSM in CARGA_A0, A=0, B=0, OPER_VALIDO=0, CONTAGEM=0, and PRONTO=1.
REQ-029 Reset asserted mid-load or during ENTREGA SHALL discard the partial or pending pair without delivering it.
REQ-030 After RST_N deasserts, the first byte SHALL be transferable on the first rising edge.

Verification
REQ-031 MSB_PRIMEIRO=0: bytes 0x34,0x12,0x0F,0xF0 on 4 consecutive edges -> A=0x1234, B=0xF00F, OPER_VALIDO=1 after 4th edge, PRONTO=0.
REQ-032 MSB_PRIMEIRO=1: bytes 0x12,0x34,0xF0,0x0F -> A=0x1234, B=0xF00F; hold OPER_ACEITO=0 for 10 cycles -> outputs unchanged; then OPER_ACEITO=1 -> OPER_VALIDO=0 and CONTAGEM=1.
REQ-033 Two bytes transferred, then LIMPA=1 with DADO_VALIDO=1 on the same edge -> A=0, B=0, state CARGA_A0, CONTAGEM unchanged; next 4 bytes form a clean pair.
REQ-034 In ENTREGA, LIMPA=1 and OPER_ACEITO=1 on the same edge -> OPER_VALIDO=0 and CONTAGEM not incremented; while OPER_VALIDO=1, DADO_VALIDO pulses do not alter A or B.
REQ-035 Deliver 256 pairs back-to-back -> CONTAGEM wraps to 0; interval from one OPER_ACEITO edge to the next OPER_VALIDO rise is 4 edges.
REQ-036 RST_N pulsed low between edges after the 3rd byte -> outputs go to reset values asynchronously; OPER_VALIDO never rises for that pair.
